// File: rtl/ptw_mem_arbiter.sv
// Arbitrates ITLB/DTLB page-table-walk reads onto one shared AXI read master, one read in flight.
// Optional watchdog on stalled reads is enabled by defining PTW_TIMEOUT_EN.
module ptw_mem_arbiter #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  ITLB_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] ITLB_ADDR,
   input  logic                  DTLB_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] DTLB_ADDR,
   output logic                  ITLB_DATA_VALID,
   output logic [DATA_WIDTH-1:0] ITLB_DATA,
   output logic                  ITLB_ERR,
   output logic                  DTLB_DATA_VALID,
   output logic [DATA_WIDTH-1:0] DTLB_DATA,
   output logic                  DTLB_ERR,
   output logic                  AXIM_ADDR_VALID,
   output logic [ADDR_WIDTH-1:0] AXIM_ADDR,
   input  logic                  AXIM_READY,
   input  logic                  AXIM_DATA_VALID,
   input  logic [DATA_WIDTH-1:0] AXIM_DATA,
   output logic                  BUSY
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic REQ_ITLB = 1'b0;
   localparam logic REQ_DTLB = 1'b1;

   state_t                state;
   state_t                state_next;
   logic                  itlb_pend;
   logic                  dtlb_pend;
   logic [ADDR_WIDTH-1:0] itlb_addr_q;
   logic [ADDR_WIDTH-1:0] dtlb_addr_q;
   logic                  last_grant;
   logic                  owner;
   logic                  axim_valid_q;
   logic [ADDR_WIDTH-1:0] axim_addr_q;
   logic                  itlb_dv_q;
   logic                  dtlb_dv_q;
   logic [DATA_WIDTH-1:0] data_q;

   logic                  itlb_cand;
   logic                  dtlb_cand;
   logic                  grant;
   logic                  grant_sel;
   logic [ADDR_WIDTH-1:0] grant_addr;
   logic                  resp;
   logic                  timeout_fire;
   logic                  timeout_hit;

   assign itlb_cand = itlb_pend | ITLB_ADDR_VALID;
   assign dtlb_cand = dtlb_pend | DTLB_ADDR_VALID;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A pulse arriving this cycle carries the freshest address, so it beats the latched copy.
   always_comb begin
      state_next   = state;
      grant        = 1'b0;
      grant_sel    = REQ_ITLB;
      grant_addr   = '0;
      resp         = 1'b0;
      timeout_fire = 1'b0;
      case (state)
         IDLE: begin
            if (itlb_cand && dtlb_cand) begin
               grant     = 1'b1;
               grant_sel = (last_grant == REQ_DTLB) ? REQ_ITLB : REQ_DTLB;
            end else if (itlb_cand) begin
               grant     = 1'b1;
               grant_sel = REQ_ITLB;
            end else if (dtlb_cand) begin
               grant     = 1'b1;
               grant_sel = REQ_DTLB;
            end
            if (grant) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (AXIM_READY) begin
               state_next = WAIT;
            end else if (timeout_hit) begin
               timeout_fire = 1'b1;
               state_next   = IDLE;
            end
         end
         WAIT: begin
            if (AXIM_DATA_VALID) begin
               resp       = 1'b1;
               state_next = IDLE;
            end else if (timeout_hit) begin
               timeout_fire = 1'b1;
               state_next   = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (grant_sel == REQ_ITLB) begin
         grant_addr = ITLB_ADDR_VALID ? ITLB_ADDR : itlb_addr_q;
      end else begin
         grant_addr = DTLB_ADDR_VALID ? DTLB_ADDR : dtlb_addr_q;
      end
   end

   // Pulses not granted on arrival are parked; a repeat pulse simply refreshes the parked address.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         itlb_pend    <= 1'b0;
         dtlb_pend    <= 1'b0;
         itlb_addr_q  <= '0;
         dtlb_addr_q  <= '0;
         last_grant   <= REQ_DTLB;
         owner        <= REQ_ITLB;
         axim_valid_q <= 1'b0;
         axim_addr_q  <= '0;
         itlb_dv_q    <= 1'b0;
         dtlb_dv_q    <= 1'b0;
         data_q       <= '0;
      end else begin
         if (grant && grant_sel == REQ_ITLB) begin
            itlb_pend <= 1'b0;
         end else if (ITLB_ADDR_VALID) begin
            itlb_pend   <= 1'b1;
            itlb_addr_q <= ITLB_ADDR;
         end
         if (grant && grant_sel == REQ_DTLB) begin
            dtlb_pend <= 1'b0;
         end else if (DTLB_ADDR_VALID) begin
            dtlb_pend   <= 1'b1;
            dtlb_addr_q <= DTLB_ADDR;
         end
         if (grant) begin
            owner       <= grant_sel;
            last_grant  <= grant_sel;
            axim_addr_q <= grant_addr;
         end
         axim_valid_q <= (state_next == ISSUE);
         itlb_dv_q    <= resp && (owner == REQ_ITLB);
         dtlb_dv_q    <= resp && (owner == REQ_DTLB);
         if (resp) begin
            data_q <= AXIM_DATA;
         end
      end
   end

`ifdef PTW_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] timeout_cnt;
   logic             itlb_err_q;
   logic             dtlb_err_q;

   // The count is one behind the cycles spent busy, hence the minus one in the limit.
   assign timeout_hit = (timeout_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         timeout_cnt <= '0;
         itlb_err_q  <= 1'b0;
         dtlb_err_q  <= 1'b0;
      end else begin
         if (grant) begin
            timeout_cnt <= '0;
         end else if (state != IDLE) begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
         end
         itlb_err_q <= timeout_fire && (owner == REQ_ITLB);
         dtlb_err_q <= timeout_fire && (owner == REQ_DTLB);
      end
   end

   assign ITLB_ERR = itlb_err_q;
   assign DTLB_ERR = dtlb_err_q;
`else
   assign timeout_hit = 1'b0;
   assign ITLB_ERR    = 1'b0;
   assign DTLB_ERR    = 1'b0;
`endif

   assign ITLB_DATA_VALID = itlb_dv_q;
   assign DTLB_DATA_VALID = dtlb_dv_q;
   assign ITLB_DATA       = data_q;
   assign DTLB_DATA       = data_q;
   assign AXIM_ADDR_VALID = axim_valid_q;
   assign AXIM_ADDR       = axim_addr_q;
   assign BUSY            = (state != IDLE);

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench for ptw_mem_arbiter: a vector table for walks and arbitration, hand sequences
// for stall, reset mid-walk and (when PTW_TIMEOUT_EN is defined) the watchdog.
module tb_ptw_mem_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
`ifdef PTW_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 255;
`endif

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          ITLB_ADDR_VALID = 1'b0;
   logic [AW-1:0] ITLB_ADDR = '0;
   logic          DTLB_ADDR_VALID = 1'b0;
   logic [AW-1:0] DTLB_ADDR = '0;
   logic          ITLB_DATA_VALID;
   logic [DW-1:0] ITLB_DATA;
   logic          ITLB_ERR;
   logic          DTLB_DATA_VALID;
   logic [DW-1:0] DTLB_DATA;
   logic          DTLB_ERR;
   logic          AXIM_ADDR_VALID;
   logic [AW-1:0] AXIM_ADDR;
   logic          AXIM_READY = 1'b0;
   logic          AXIM_DATA_VALID = 1'b0;
   logic [DW-1:0] AXIM_DATA = '0;
   logic          BUSY;

   int checks = 0;
   int errors = 0;
   int accept_cnt = 0;

   always #5 CLK = ~CLK;

   ptw_mem_arbiter #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .ITLB_ADDR_VALID(ITLB_ADDR_VALID),
      .ITLB_ADDR      (ITLB_ADDR),
      .DTLB_ADDR_VALID(DTLB_ADDR_VALID),
      .DTLB_ADDR      (DTLB_ADDR),
      .ITLB_DATA_VALID(ITLB_DATA_VALID),
      .ITLB_DATA      (ITLB_DATA),
      .ITLB_ERR       (ITLB_ERR),
      .DTLB_DATA_VALID(DTLB_DATA_VALID),
      .DTLB_DATA      (DTLB_DATA),
      .DTLB_ERR       (DTLB_ERR),
      .AXIM_ADDR_VALID(AXIM_ADDR_VALID),
      .AXIM_ADDR      (AXIM_ADDR),
      .AXIM_READY     (AXIM_READY),
      .AXIM_DATA_VALID(AXIM_DATA_VALID),
      .AXIM_DATA      (AXIM_DATA),
      .BUSY           (BUSY)
   );

   // Handshake acceptances as seen by the master, sampled on the edge itself.
   always @(posedge CLK) begin
      if (RST_N && AXIM_ADDR_VALID && AXIM_READY) begin
         accept_cnt++;
      end
   end

   typedef struct {
      logic          rst_n;
      logic          iv;
      logic [AW-1:0] ia;
      logic          dv;
      logic [AW-1:0] da;
      logic          rdy;
      logic          mdv;
      logic [DW-1:0] md;
      logic          e_axv;
      logic [AW-1:0] e_axa;
      logic          e_idv;
      logic          e_ddv;
      logic [DW-1:0] e_data;
      logic          e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst_n, logic iv, logic [AW-1:0] ia, logic dv,
                               logic [AW-1:0] da, logic rdy, logic mdv, logic [DW-1:0] md,
                               logic e_axv, logic [AW-1:0] e_axa, logic e_idv, logic e_ddv,
                               logic [DW-1:0] e_data, logic e_busy);
      vec_t v;
      v.rst_n = rst_n; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da;
      v.rdy = rdy; v.mdv = mdv; v.md = md;
      v.e_axv = e_axv; v.e_axa = e_axa; v.e_idv = e_idv; v.e_ddv = e_ddv;
      v.e_data = e_data; v.e_busy = e_busy;
      return v;
   endfunction

   function automatic vec_t mkin(logic rst_n, logic iv, logic [AW-1:0] ia, logic dv,
                                 logic [AW-1:0] da, logic rdy, logic mdv, logic [DW-1:0] md);
      return mk(rst_n, iv, ia, dv, da, rdy, mdv, md, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endfunction

   task automatic applyStimulus(input vec_t v);
      RST_N           = v.rst_n;
      ITLB_ADDR_VALID = v.iv;
      ITLB_ADDR       = v.ia;
      DTLB_ADDR_VALID = v.dv;
      DTLB_ADDR       = v.da;
      AXIM_READY      = v.rdy;
      AXIM_DATA_VALID = v.mdv;
      AXIM_DATA       = v.md;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag, input logic [DW-1:0] exp_data);
      checkOutput({tag, " busy"}, 64'(BUSY), 64'd0);
      checkOutput({tag, " axim_valid"}, 64'(AXIM_ADDR_VALID), 64'd0);
      checkOutput({tag, " itlb_dv"}, 64'(ITLB_DATA_VALID), 64'd0);
      checkOutput({tag, " dtlb_dv"}, 64'(DTLB_DATA_VALID), 64'd0);
      checkOutput({tag, " itlb_data"}, ITLB_DATA, exp_data);
      checkOutput({tag, " dtlb_data"}, DTLB_DATA, exp_data);
   endtask

   initial begin
      int acc0;
      string tag;

      // Walk table: inputs driven for one cycle, outputs checked just after that edge.
      //               rst iv ia               dv da               rdy mdv md
      //               axv axa              idv ddv data             busy
      vecs.push_back(mk(1, 1, 64'h8000_1000, 0, 64'h0,         1, 0, 64'h0,
                        1, 64'h8000_1000, 0, 0, 64'h0,         1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         1, 0, 64'h0,
                        0, 64'h8000_1000, 0, 0, 64'h0,         1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 1, 64'h2000_04CF,
                        0, 64'h8000_1000, 1, 0, 64'h2000_04CF, 0));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 0, 64'h0,
                        0, 64'h8000_1000, 0, 0, 64'h2000_04CF, 0));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 1, 64'hDEAD_BEEF,
                        0, 64'h8000_1000, 0, 0, 64'h2000_04CF, 0));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 0, 64'h0,
                        0, 64'h8000_1000, 0, 0, 64'h2000_04CF, 0));
      vecs.push_back(mk(0, 0, 64'h0,         0, 64'h0,         0, 0, 64'h0,
                        0, 64'h0,         0, 0, 64'h0,         0));
      vecs.push_back(mk(1, 1, 64'h1111_0000, 1, 64'h2222_0000, 0, 0, 64'h0,
                        1, 64'h1111_0000, 0, 0, 64'h0,         1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         1, 0, 64'h0,
                        0, 64'h1111_0000, 0, 0, 64'h0,         1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 1, 64'hAAAA,
                        0, 64'h1111_0000, 1, 0, 64'hAAAA,      0));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 0, 64'h0,
                        1, 64'h2222_0000, 0, 0, 64'hAAAA,      1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         1, 0, 64'h0,
                        0, 64'h2222_0000, 0, 0, 64'hAAAA,      1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 1, 64'hBBBB,
                        0, 64'h2222_0000, 0, 1, 64'hBBBB,      0));
      vecs.push_back(mk(1, 1, 64'h3333_0000, 1, 64'h4444_0000, 0, 0, 64'h0,
                        1, 64'h3333_0000, 0, 0, 64'hBBBB,      1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         1, 0, 64'h0,
                        0, 64'h3333_0000, 0, 0, 64'hBBBB,      1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 1, 64'hCCCC,
                        0, 64'h3333_0000, 1, 0, 64'hCCCC,      0));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 0, 64'h0,
                        1, 64'h4444_0000, 0, 0, 64'hCCCC,      1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         1, 0, 64'h0,
                        0, 64'h4444_0000, 0, 0, 64'hCCCC,      1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 1, 64'hDDDD,
                        0, 64'h4444_0000, 0, 1, 64'hDDDD,      0));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 0, 64'h0,
                        0, 64'h4444_0000, 0, 0, 64'hDDDD,      0));
      vecs.push_back(mk(1, 1, 64'h6666_0000, 1, 64'h5555_0000, 0, 0, 64'h0,
                        1, 64'h6666_0000, 0, 0, 64'hDDDD,      1));
      vecs.push_back(mk(1, 0, 64'h0,         1, 64'h7777_0000, 1, 0, 64'h0,
                        0, 64'h6666_0000, 0, 0, 64'hDDDD,      1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 1, 64'hEEEE,
                        0, 64'h6666_0000, 1, 0, 64'hEEEE,      0));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 0, 64'h0,
                        1, 64'h7777_0000, 0, 0, 64'hEEEE,      1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         1, 0, 64'h0,
                        0, 64'h7777_0000, 0, 0, 64'hEEEE,      1));
      vecs.push_back(mk(1, 0, 64'h0,         0, 64'h0,         0, 1, 64'h1234,
                        0, 64'h7777_0000, 0, 1, 64'h1234,      0));

      // Reset values while RST_N is held low.
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checkIdleOutputs("reset", 64'h0);
      checkOutput("reset axim_addr", AXIM_ADDR, 64'h0);
      checkOutput("reset itlb_err", 64'(ITLB_ERR), 64'd0);
      checkOutput("reset dtlb_err", 64'(DTLB_ERR), 64'd0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         tag = $sformatf("row%0d", i);
         checkOutput({tag, " axim_valid"}, 64'(AXIM_ADDR_VALID), 64'(vecs[i].e_axv));
         checkOutput({tag, " axim_addr"}, AXIM_ADDR, vecs[i].e_axa);
         checkOutput({tag, " itlb_dv"}, 64'(ITLB_DATA_VALID), 64'(vecs[i].e_idv));
         checkOutput({tag, " dtlb_dv"}, 64'(DTLB_DATA_VALID), 64'(vecs[i].e_ddv));
         checkOutput({tag, " itlb_data"}, ITLB_DATA, vecs[i].e_data);
         checkOutput({tag, " dtlb_data"}, DTLB_DATA, vecs[i].e_data);
         checkOutput({tag, " busy"}, 64'(BUSY), 64'(vecs[i].e_busy));
         checkOutput({tag, " errs"}, 64'({ITLB_ERR, DTLB_ERR}), 64'd0);
      end

      // Master stalls for five cycles; a stray beat mid-stall must be ignored.
      applyStimulus(mkin(1, 0, 64'h0, 1, 64'h5555_A000, 0, 0, 64'h0));
      acc0 = accept_cnt;
      checkOutput("stall c1 valid", 64'(AXIM_ADDR_VALID), 64'd1);
      checkOutput("stall c1 addr", AXIM_ADDR, 64'h5555_A000);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(mkin(1, 0, 64'h0, 0, 64'h0, 0, (i == 2), 64'hBAD));
         tag = $sformatf("stall c%0d", i + 2);
         checkOutput({tag, " valid"}, 64'(AXIM_ADDR_VALID), 64'd1);
         checkOutput({tag, " addr"}, AXIM_ADDR, 64'h5555_A000);
         checkOutput({tag, " dvs"}, 64'({ITLB_DATA_VALID, DTLB_DATA_VALID}), 64'd0);
         checkOutput({tag, " data"}, DTLB_DATA, 64'h1234);
      end
      applyStimulus(mkin(1, 0, 64'h0, 0, 64'h0, 1, 0, 64'h0));
      checkOutput("stall accepted valid", 64'(AXIM_ADDR_VALID), 64'd0);
      checkOutput("stall accepted busy", 64'(BUSY), 64'd1);
      checkOutput("stall accept count", 64'(accept_cnt - acc0), 64'd1);
      applyStimulus(mkin(1, 0, 64'h0, 0, 64'h0, 0, 1, 64'h0BAD_F00D));
      checkOutput("stall resp dtlb_dv", 64'(DTLB_DATA_VALID), 64'd1);
      checkOutput("stall resp itlb_dv", 64'(ITLB_DATA_VALID), 64'd0);
      checkOutput("stall resp data", DTLB_DATA, 64'h0BAD_F00D);

      // Reset while waiting for data, then a late beat that must be dropped.
      applyStimulus(mkin(1, 1, 64'h9000_0000, 0, 64'h0, 1, 0, 64'h0));
      applyStimulus(mkin(1, 0, 64'h0, 0, 64'h0, 1, 0, 64'h0));
      checkOutput("midrst wait busy", 64'(BUSY), 64'd1);
      RST_N = 1'b0;
      #2;
      checkIdleOutputs("midrst asserted", 64'h0);
      checkOutput("midrst axim_addr", AXIM_ADDR, 64'h0);
      applyStimulus(mkin(0, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0));
      applyStimulus(mkin(1, 0, 64'h0, 0, 64'h0, 0, 1, 64'hFEED));
      checkIdleOutputs("midrst late beat", 64'h0);
      applyStimulus(mkin(1, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0));
      checkIdleOutputs("midrst after", 64'h0);
      checkOutput("midrst errs", 64'({ITLB_ERR, DTLB_ERR}), 64'd0);

`ifdef PTW_TIMEOUT_EN
      // Master never answers: DTLB_ERR pulses 16 cycles after the grant edge.
      applyStimulus(mkin(1, 0, 64'h0, 1, 64'hC0DE_0000, 0, 0, 64'h0));
      checkOutput("tmo granted", 64'(AXIM_ADDR_VALID), 64'd1);
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(mkin(1, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0));
         tag = $sformatf("tmo k%0d", k);
         if (k < 16) begin
            checkOutput({tag, " dtlb_err"}, 64'(DTLB_ERR), 64'd0);
            checkOutput({tag, " busy"}, 64'(BUSY), 64'd1);
         end else begin
            checkOutput({tag, " dtlb_err"}, 64'(DTLB_ERR), 64'd1);
            checkOutput({tag, " itlb_err"}, 64'(ITLB_ERR), 64'd0);
            checkOutput({tag, " busy"}, 64'(BUSY), 64'd0);
            checkOutput({tag, " valid"}, 64'(AXIM_ADDR_VALID), 64'd0);
            checkOutput({tag, " dvs"}, 64'({ITLB_DATA_VALID, DTLB_DATA_VALID}), 64'd0);
         end
      end
      applyStimulus(mkin(1, 0, 64'h0, 0, 64'h0, 0, 0, 64'h0));
      checkOutput("tmo err pulse ends", 64'(DTLB_ERR), 64'd0);
      checkOutput("tmo idle", 64'(BUSY), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
